// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential BCD-to-binary converter (reverse double dabble)
//
// Converts a packed BCD word to binary. Each clock performs one iteration:
// shift right by one, then subtract 3 from every BCD digit that is 8 or more.
// Conversion time does not depend on the operand, including digits above 9.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bcd_in     packed BCD operand, MS digit in the top nibble, sampled on accept
//   in_valid   operand present
//   in_ready   converter idle, can accept
//   bin_out    binary result, held while out_valid
//   err        qualifies bin_out: some captured digit was above 9
//   out_valid  result available
//   out_ready  consumer takes result
//   busy       conversion or result pending
module bcd2bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SR_W-1:0]     sr_q, sr_d;          // {bcd_part, bin_part}
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                flag_q, flag_d;      // captured operand had a non-decimal digit
    logic [BIN_W-1:0]    bin_out_q, bin_out_d;
    logic                err_q, err_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;

    logic                digit_bad;
    logic [SR_W-1:0]     sr_step;

    // Non-decimal digit detection on the incoming operand and one
    // reverse double-dabble iteration on the current shift register.
    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end

        sr_step = sr_q >> 1;
        // Each digit is corrected on its own; no borrow crosses nibbles.
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_step[BIN_W + 4*i + 3]) begin
                sr_step[BIN_W + 4*i +: 4] = sr_step[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        flag_d      = flag_q;
        bin_out_d   = bin_out_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sr_d       = {bcd_in, {BIN_W{1'b0}}};
                    flag_d     = digit_bad;
                    cnt_d      = '0;
                    state_d    = S_CONV;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_CONV: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // First DONE cycle publishes the result; later cycles wait
                // for the consumer while holding it stable.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    bin_out_d   = flag_q ? '0 : sr_q[BIN_W-1:0];
                    err_d       = flag_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
            bin_out_q   <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
            bin_out_q   <= bin_out_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign bin_out   = bin_out_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
